// File: rtl/pe_sequencer.sv
// pe_sequencer: control sequencer for a processing element.
// Walks IDLE -> LOAD or RUN -> DRAIN -> DONE and emits registered scratchpad,
// psum and address-advance strobes. All outputs come straight from flops.
// Optional feature macro: PE_SEQ_STALL_EN adds a 'stall' input that freezes
// RUN/DRAIN progress and masks the pulse outputs while high.
//
// Handshake: start/load are level requests sampled on the rising clock edge
// only while IDLE (load wins); they are ignored in every other state.
module pe_sequencer #(
  parameter int P_W         = 5,
  parameter int Q_W         = 3,
  parameter int S_W         = 4,
  parameter int TAP         = 4,
  parameter int ADW2_PERIOD = 5
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           load,
  input  logic [P_W-1:0] P,
  input  logic [Q_W-1:0] Q,
  input  logic [S_W-1:0] S,
  output logic           ifw,
  output logic           fsw,
  output logic           psw,
  output logic           adw,
  output logic           adw2,
  output logic           ifa,
  output logic           mux1,
  output logic           mux2,
  output logic           busy,
  output logic           complete,
  output logic           cfg_err
`ifdef PE_SEQ_STALL_EN
  ,
  input  logic           stall
`endif
);

  // t needs to hold the value 2 even when TAP is 2, hence clog2(TAP+1).
  localparam int T_W = $clog2(TAP + 1);
  localparam int A_W = $clog2(ADW2_PERIOD + 1);
  localparam int R_W = P_W + T_W;
  localparam int W_W = P_W + Q_W + S_W + T_W;
  localparam int M_W = P_W + 1;

  localparam logic [T_W-1:0] T_LAST = T_W'(TAP - 1);
  localparam logic [T_W-1:0] T_MUX2 = T_W'(2);
  localparam logic [A_W-1:0] A_LAST = A_W'(ADW2_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic ifw;
    logic fsw;
    logic psw;
    logic adw;
    logic adw2;
    logic ifa;
    logic mux1;
    logic mux2;
    logic busy;
    logic complete;
    logic cfg_err;
  } out_t;

  state_e         state_q, state_d;
  logic           arm_q;
  logic [T_W-1:0] t_q, t_d;
  logic [W_W-1:0] w_q, w_d;
  logic [R_W-1:0] r_q, r_d;
  logic [A_W-1:0] a_q, a_d;
  logic [M_W-1:0] m_q, m_d;
  logic [P_W-1:0] p_q, p_d;
  logic [Q_W-1:0] q_q, q_d;
  logic [S_W-1:0] s_q, s_d;
  out_t           out_q, out_d;
  logic           zero_start;
  logic           stall_i;
  logic           hold;
  logic [W_W-1:0] total;
  logic [R_W-1:0] ptap_q;
  logic [R_W-1:0] ptap_d;

`ifdef PE_SEQ_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  // Full-width products so large passes never wrap.
  assign total  = W_W'(s_q) * W_W'(p_q) * W_W'(q_q) * W_W'(TAP);
  assign ptap_q = R_W'(p_q) * R_W'(TAP);
  assign ptap_d = R_W'(p_d) * R_W'(TAP);
  assign hold   = stall_i && (state_q == RUN || state_q == DRAIN);

  // Next-state and counter update; arm_q keeps the first edge after reset quiet.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    w_d        = w_q;
    r_d        = r_q;
    a_d        = a_q;
    m_d        = m_q;
    p_d        = p_q;
    q_d        = q_q;
    s_d        = s_q;
    zero_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_q) begin
          if (load) begin
            state_d = LOAD;
          end else if (start) begin
            p_d = P;
            q_d = Q;
            s_d = S;
            t_d = '0;
            w_d = '0;
            r_d = '0;
            a_d = '0;
            m_d = '0;
            if (P == '0 || Q == '0 || S == '0) begin
              state_d    = DONE;
              zero_start = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
      end
      LOAD: begin
        if (!load) state_d = IDLE;
      end
      RUN: begin
        if (!stall_i) begin
          t_d = (t_q == T_LAST) ? '0 : t_q + T_W'(1);
          r_d = (r_q == ptap_q - R_W'(1)) ? '0 : r_q + R_W'(1);
          a_d = (a_q == A_LAST) ? '0 : a_q + A_W'(1);
          if (t_q == T_MUX2 && m_q < {1'b0, p_q}) m_d = m_q + M_W'(1);
          if (w_q == total - W_W'(1)) state_d = DRAIN;
          else w_d = w_q + W_W'(1);
        end
      end
      DRAIN: begin
        if (!stall_i) begin
          t_d = (t_q == T_LAST) ? '0 : t_q + T_W'(1);
          if (t_q == T_LAST) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state/counters so the flopped outputs line up with the state.
  always_comb begin
    out_d      = '0;
    out_d.busy = (state_d != IDLE);
    case (state_d)
      LOAD: begin
        out_d.ifw  = 1'b1;
        out_d.fsw  = 1'b1;
        out_d.mux2 = 1'b1;
      end
      RUN: begin
        if (!hold) begin
          out_d.psw  = (t_d == '0);
          out_d.adw  = (t_d == T_LAST);
          out_d.adw2 = (a_d == A_LAST);
          out_d.ifa  = (r_d == ptap_d - R_W'(1));
          out_d.mux2 = (t_d == T_MUX2) && (m_d < {1'b0, p_d});
        end
      end
      DRAIN: out_d.mux1 = !hold;
      DONE: begin
        out_d.complete = 1'b1;
        out_d.cfg_err  = zero_start;
      end
      default: out_d = '0;
    endcase
  end

  // State, counters, latched dimensions and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      arm_q   <= 1'b0;
      t_q     <= '0;
      w_q     <= '0;
      r_q     <= '0;
      a_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      s_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= 1'b1;
      t_q     <= t_d;
      w_q     <= w_d;
      r_q     <= r_d;
      a_q     <= a_d;
      m_q     <= m_d;
      p_q     <= p_d;
      q_q     <= q_d;
      s_q     <= s_d;
      out_q   <= out_d;
    end
  end

  assign ifw      = out_q.ifw;
  assign fsw      = out_q.fsw;
  assign psw      = out_q.psw;
  assign adw      = out_q.adw;
  assign adw2     = out_q.adw2;
  assign ifa      = out_q.ifa;
  assign mux1     = out_q.mux1;
  assign mux2     = out_q.mux2;
  assign busy     = out_q.busy;
  assign complete = out_q.complete;
  assign cfg_err  = out_q.cfg_err;

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Parameter P_W, default 5: width of P (ofmap row length).
REQ-002 Parameter Q_W, default 3: width of Q (filter rows).
REQ-003 Parameter S_W, default 4: width of S (channel count).
REQ-004 Parameter TAP, default 4, range 2..16: MAC cycles per psum step.
REQ-005 Parameter ADW2_PERIOD, default 5, minimum 2: cycle period of the adw2 pulse in RUN.
REQ-006 Ports:
- clk  in  1: clock, rising edge.
- rstn  in  1: asynchronous active-low reset.
- start  in  1: launch pass.
- load  in  1: weight/ifmap load request.
- P  in  P_W; Q  in  Q_W; S  in  S_W: pass dimensions.
- ifw  out  1: ifmap scratchpad write enable.
- fsw  out  1: filter scratchpad write enable.
- psw  out  1: psum write enable.
- adw  out  1: psum address advance.
- adw2  out  1: secondary address advance.
- ifa  out  1: ifmap address advance.
- mux1  out  1: accumulate-select for the drain.
- mux2  out  1: psum-zero select.
- busy  out  1: not IDLE.
- complete  out  1: one-cycle done pulse.
- cfg_err  out  1: one-cycle zero-dimension pulse.

Function
REQ-007 The block SHALL be a registered FSM with states IDLE, LOAD, RUN, DRAIN, DONE; all outputs SHALL be registered.
REQ-008 In IDLE: load=1 -> LOAD; else start=1 -> RUN; load has priority over start.
REQ-009 In LOAD: ifw=fsw=mux2=1 every cycle; load=0 -> IDLE next cycle.
REQ-010 On IDLE->RUN, P, Q and S SHALL be latched; input changes after that have no effect until the next start.
REQ-011 If latched P, Q or S is 0, the FSM SHALL go to DONE instead of RUN and assert cfg_err with complete.
REQ-012 In RUN, counters: t cycles 0..TAP-1; w counts 0..TOTAL-1, where TOTAL = S*P*Q*TAP computed at full width P_W+Q_W+S_W+clog2(TAP) with no truncation; r cycles 0..P*TAP-1; a cycles 0..ADW2_PERIOD-1. RUN cycle 0 is the first RUN cycle, with all counters 0.
REQ-013 In RUN: psw=1 when t==0; adw=1 when t==TAP-1; ifa=1 when r==P*TAP-1, with r wrapping to 0; adw2=1 when a==ADW2_PERIOD-1.
REQ-014 mux2=1 in RUN when t==2 and fewer than P mux2 pulses have been issued since start.
REQ-015 When w==TOTAL-1, the FSM SHALL go to DRAIN; DRAIN SHALL last exactly TAP cycles with mux1=1 and all other pulses 0.
REQ-016 DONE SHALL last one cycle with complete=1, then the FSM SHALL return to IDLE.
REQ-017 start and load outside IDLE SHALL be ignored; start held high across DONE SHALL relaunch only after one IDLE cycle.
REQ-018 busy=1 in LOAD, RUN, DRAIN and DONE.

Reset
REQ-019 rstn=0 SHALL immediately force IDLE, clear all counters and latched dimensions, and drive every output to 0, including mid-RUN.
REQ-020 After reset release, the first state transition SHALL occur on the second rising clk edge.

Configuration
REQ-021 With PE_SEQ_STALL_EN defined, the block SHALL add input stall (1 bit); stall=1 in RUN or DRAIN SHALL freeze all counters and the state, and force psw, adw, adw2, ifa, mux1 and mux2 to 0.
REQ-022 Without PE_SEQ_STALL_EN, the stall port SHALL be absent and the sequence SHALL never pause.

Verification
REQ-023 P=2, Q=1, S=1, TAP=4, start pulse -> psw at RUN cycles 0,4; adw at 3,7; mux2 at 2,6; ifa at 7; mux1 at 8-11; complete at cycle 12.
REQ-024 load high for 6 cycles in IDLE, start also high -> ifw=fsw=mux2=1 for 6 cycles, no RUN entered while load=1.
REQ-025 P=0, start pulse -> complete=cfg_err=1 one cycle after start sampled, psw never asserted.
REQ-026 rstn low at RUN cycle 5 of P=3, Q=2, S=2 -> all outputs 0 immediately, IDLE, next start restarts at w=0.
REQ-027 P=31, Q=7, S=15, TAP=4 -> exactly 13020 RUN cycles, 3255 psw pulses, complete once.
REQ-028 With PE_SEQ_STALL_EN, stall high for 3 cycles at RUN cycle 2 (P=2, Q=1, S=1) -> complete delayed to cycle 15, pulse counts unchanged.
